rom_fetch_arbiter: RTL and testbench

Shares one SDRAM port between the main CPU program ROM, the sound CPU program ROM and the ROM download stream. The block sits between the CPU/ioctl side and the SDRAM controller's toggle-handshake port, in the same `clk_sys` domain as the ROM consumers. It keeps a one-word tag cache per CPU so a CPU re-reading the same 16-bit word causes no SDRAM traffic. It gives download writes absolute priority and round-robins CPU misses.

---
 rtl/rom_fetch_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rom_fetch_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_arbiter.sv
// Shares one toggle-handshake SDRAM port between main CPU ROM, sound CPU ROM and
// the ROM download stream. Each CPU keeps a single-word tag cache.
module rom_fetch_arbiter #(
  parameter int              AW        = 23,
  parameter logic [AW-1:0]   MAIN_BASE = '0,
  parameter logic [AW-1:0]   SND_BASE  = AW'(23'h4000)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic [13:0]   main_addr,
  output logic [15:0]   main_q,
  output logic          main_ready,
  input  logic [11:0]   snd_addr,
  output logic [15:0]   snd_q,
  output logic          snd_ready,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_a,
  output logic [1:0]    mem_ds,
  output logic          mem_we,
  output logic [15:0]   mem_d,
  input  logic [15:0]   mem_q,
  output logic          dl_overrun
);

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_WAIT} state_t;
  typedef enum logic [1:0] {G_WR, G_MAIN, G_SND} gnt_t;

  state_t        state_reg, state_next;
  gnt_t          gnt_reg, issue_gnt;
  logic          issue;
  logic          ack_match, done, consume;
  logic          main_miss, snd_miss, pick_snd;
  logic          dl_edge;
  logic [AW-1:0] issue_a;
  logic [13:0]   issue_tag;

  logic          dl_wr_prev_reg;
  logic [22:0]   buf_addr_reg;
  logic          buf_a0_reg;
  logic [7:0]    buf_data_reg;
  logic          dl_pend_reg;
  logic          dl_overrun_reg;
  logic [13:0]   main_tag_reg;
  logic          main_vld_reg;
  logic [15:0]   main_q_reg;
  logic [11:0]   snd_tag_reg;
  logic          snd_vld_reg;
  logic [15:0]   snd_q_reg;
  logic [13:0]   pend_tag_reg;
  logic          last_snd_reg;
  logic          mem_req_reg, mem_we_reg;
  logic [AW-1:0] mem_a_reg;
  logic [1:0]    mem_ds_reg;
  logic [15:0]   mem_d_reg;

  // Byte address bit 24 lies beyond the SDRAM word space.
  logic unused_dl_msb;
  assign unused_dl_msb = dl_addr[24];

  assign main_ready = main_vld_reg & (main_tag_reg == main_addr);
  assign snd_ready  = snd_vld_reg & (snd_tag_reg == snd_addr);
  assign main_q     = main_q_reg;
  assign snd_q      = snd_q_reg;
  assign mem_req    = mem_req_reg;
  assign mem_a      = mem_a_reg;
  assign mem_ds     = mem_ds_reg;
  assign mem_we     = mem_we_reg;
  assign mem_d      = mem_d_reg;
  assign dl_overrun = dl_overrun_reg;

  always_comb begin
    ack_match  = (mem_ack == mem_req_reg);
    main_miss  = ~main_ready & ~dl_active;
    snd_miss   = ~snd_ready & ~dl_active;
    // Sound wins only when alone or when main was served last.
    pick_snd   = snd_miss & (~main_miss | ~last_snd_reg);
    dl_edge    = dl_wr & ~dl_wr_prev_reg;
    done       = (state_reg == ST_WAIT) & ack_match;
    consume    = done & (gnt_reg == G_WR);
    state_next = state_reg;
    issue      = 1'b0;
    issue_gnt  = G_WR;
    case (state_reg)
      ST_SYNC: if (ack_match) state_next = ST_IDLE;
      ST_IDLE: begin
        if (dl_pend_reg) begin
          issue = 1'b1;
        end else if (main_miss | snd_miss) begin
          issue     = 1'b1;
          issue_gnt = pick_snd ? G_SND : G_MAIN;
        end
        if (issue) state_next = ST_WAIT;
      end
      ST_WAIT: if (ack_match) state_next = ST_IDLE;
      default: state_next = ST_SYNC;
    endcase
    issue_a   = (issue_gnt == G_SND) ? SND_BASE + AW'(snd_addr) : MAIN_BASE + AW'(main_addr);
    issue_tag = (issue_gnt == G_SND) ? {2'b00, snd_addr} : main_addr;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_SYNC;
      gnt_reg        <= G_WR;
      dl_wr_prev_reg <= 1'b0;
      buf_addr_reg   <= '0;
      buf_a0_reg     <= 1'b0;
      buf_data_reg   <= '0;
      dl_pend_reg    <= 1'b0;
      dl_overrun_reg <= 1'b0;
      main_tag_reg   <= '0;
      main_vld_reg   <= 1'b0;
      main_q_reg     <= '0;
      snd_tag_reg    <= '0;
      snd_vld_reg    <= 1'b0;
      snd_q_reg      <= '0;
      pend_tag_reg   <= '0;
      last_snd_reg   <= 1'b1;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_a_reg      <= '0;
      mem_ds_reg     <= '0;
      mem_d_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      dl_wr_prev_reg <= dl_wr;

      if (consume) dl_pend_reg <= 1'b0;
      if (dl_edge) begin
        if (dl_pend_reg & ~consume) begin
          dl_overrun_reg <= 1'b1;
        end else begin
          buf_addr_reg <= dl_addr[23:1];
          buf_a0_reg   <= dl_addr[0];
          buf_data_reg <= dl_data;
          dl_pend_reg  <= 1'b1;
        end
      end

      if (issue) begin
        gnt_reg      <= issue_gnt;
        mem_req_reg  <= ~mem_req_reg;
        pend_tag_reg <= issue_tag;
        if (issue_gnt == G_WR) begin
          mem_a_reg  <= AW'(buf_addr_reg);
          mem_ds_reg <= {buf_a0_reg, ~buf_a0_reg};
          mem_d_reg  <= {buf_data_reg, buf_data_reg};
          mem_we_reg <= 1'b1;
        end else begin
          mem_a_reg  <= issue_a;
          mem_ds_reg <= 2'b11;
          mem_we_reg <= 1'b0;
        end
      end

      if (done & (gnt_reg == G_MAIN)) begin
        main_q_reg   <= mem_q;
        main_tag_reg <= pend_tag_reg;
        main_vld_reg <= 1'b1;
        last_snd_reg <= 1'b0;
      end
      if (done & (gnt_reg == G_SND)) begin
        snd_q_reg    <= mem_q;
        snd_tag_reg  <= pend_tag_reg[11:0];
        snd_vld_reg  <= 1'b1;
        last_snd_reg <= 1'b1;
      end
      // A download invalidates both caches, including a read finishing right now.
      if (dl_active) begin
        main_vld_reg <= 1'b0;
        snd_vld_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter; the SDRAM side is driven by hand from the
// stimulus thread so every ack time and data word is fixed.
module tb_rom_fetch_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset, dl_active, dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [13:0] main_addr;
  logic [15:0] main_q;
  logic        main_ready;
  logic [11:0] snd_addr;
  logic [15:0] snd_q;
  logic        snd_ready;
  logic        mem_req, mem_ack, mem_we, dl_overrun;
  logic [22:0] mem_a;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d, mem_q;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  logic [22:0] a1, a2;

  rom_fetch_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .main_addr(main_addr), .main_q(main_q),
    .main_ready(main_ready), .snd_addr(snd_addr), .snd_q(snd_q), .snd_ready(snd_ready),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_ds(mem_ds),
    .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q), .dl_overrun(dl_overrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Waits (bounded) for a new request toggle; returns the cycles waited.
  task automatic wait_req(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk_sys);
      cycles++;
    end while (mem_req == mem_ack && cycles < 30);
    check({tag, "_issued"}, {31'd0, mem_req != mem_ack}, 32'd1);
  endtask

  task automatic do_ack(input int dly, input logic [15:0] q);
    repeat (dly) @(negedge clk_sys);
    $display("txn a=%h ds=%b we=%b d=%h q=%h", mem_a, mem_ds, mem_we, mem_d, q);
    mem_q   = q;
    mem_ack = mem_req;
    @(negedge clk_sys);
  endtask

  task automatic dl_pulse(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    @(negedge clk_sys);
    dl_wr   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dl_active = 1'b1; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    main_addr = '0; snd_addr = '0; mem_ack = 1'b0; mem_q = '0;
    repeat (2) @(negedge clk_sys);
    check("rst_req", {31'd0, mem_req}, 0);
    check("rst_a", {9'd0, mem_a}, 0);
    check("rst_ds_we", {29'd0, mem_ds, mem_we}, 0);
    check("rst_d", {16'd0, mem_d}, 0);
    check("rst_q", {main_q, snd_q}, 0);
    check("rst_ready", {30'd0, main_ready, snd_ready}, 0);
    check("rst_ovr", {31'd0, dl_overrun}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("idle_no_req", {31'd0, mem_req}, 0);

    // Main hit/miss; both caches empty, main wins the first tie.
    dl_active = 1'b0; main_addr = 14'h0010; snd_addr = 12'h007;
    wait_req("main_miss", lat);
    check("main_miss_lat", lat, 1);
    check("main_miss_a", {9'd0, mem_a}, 32'h10);
    check("main_miss_ds_we", {29'd0, mem_ds, mem_we}, 32'b110);
    do_ack(5, 16'hA55A);
    check("main_fill", {15'd0, main_ready, main_q}, 32'h1_A55A);
    wait_req("snd_miss", lat);
    check("snd_miss_lat", lat, 1);
    check("snd_miss_a", {9'd0, mem_a}, 32'h4007);
    do_ack(2, 16'h1234);
    check("snd_fill", {15'd0, snd_ready, snd_q}, 32'h1_1234);
    repeat (10) @(negedge clk_sys);
    check("hit_no_toggle", {31'd0, mem_req != mem_ack}, 0);
    check("hit_ready", {30'd0, main_ready, snd_ready}, 32'b11);

    // Simultaneous misses with round-robin.
    main_addr = 14'h0001; snd_addr = 12'h002;
    wait_req("rr_main", lat);
    check("rr_main_a", {9'd0, mem_a}, 32'h1);
    do_ack(2, 16'h0101);
    main_addr = 14'h0009;
    wait_req("rr_snd", lat);
    check("rr_snd_a", {9'd0, mem_a}, 32'h4002);
    do_ack(1, 16'h0202);
    check("rr_snd_fill", {15'd0, snd_ready, snd_q}, 32'h1_0202);
    wait_req("rr_main9", lat);
    check("rr_main9_a", {9'd0, mem_a}, 32'h9);
    do_ack(1, 16'h0909);
    main_addr = 14'h0020; snd_addr = 12'h030;
    wait_req("rr2_snd", lat);
    check("rr2_snd_first_a", {9'd0, mem_a}, 32'h4030);
    do_ack(1, 16'h3030);
    wait_req("rr2_main", lat);
    check("rr2_main_a", {9'd0, mem_a}, 32'h20);
    do_ack(1, 16'h2020);
    check("rr2_main_fill", {15'd0, main_ready, main_q}, 32'h1_2020);

    // Download write.
    dl_active = 1'b1;
    @(negedge clk_sys);
    check("dl_ready_low", {30'd0, main_ready, snd_ready}, 0);
    dl_pulse(25'h00003, 8'h7E);
    wait_req("dl_wr", lat);
    check("dl_wr_a", {9'd0, mem_a}, 32'h1);
    check("dl_wr_ds_we", {29'd0, mem_ds, mem_we}, 32'b101);
    check("dl_wr_d", {16'd0, mem_d}, 32'h7E7E);
    check("dl_wait_ready_low", {30'd0, main_ready, snd_ready}, 0);
    do_ack(3, 16'h0000);
    repeat (3) @(negedge clk_sys);
    check("dl_single_write", {31'd0, mem_req != mem_ack}, 0);
    check("dl_no_ovr", {31'd0, dl_overrun}, 0);
    dl_active = 1'b0;
    wait_req("refetch1", lat);
    a1 = mem_a;
    do_ack(1, 16'hAAAA);
    wait_req("refetch2", lat);
    a2 = mem_a;
    do_ack(1, 16'hBBBB);
    check("refetch_main", {31'd0, (a1 == 23'h20) || (a2 == 23'h20)}, 1);
    check("refetch_main_q", {15'd0, main_ready, main_q},
          {15'd0, 1'b1, (a1 == 23'h20) ? 16'hAAAA : 16'hBBBB});

    // Overrun: more bytes arrive while the first write is outstanding.
    dl_active = 1'b1;
    dl_pulse(25'h00004, 8'h11);
    wait_req("ovr_wr", lat);
    check("ovr_wr_a_ds", {7'd0, mem_a, mem_ds}, {7'd0, 23'h2, 2'b01});
    dl_pulse(25'h00006, 8'h22);
    dl_pulse(25'h00008, 8'h33);
    @(negedge clk_sys);
    check("ovr_flag", {31'd0, dl_overrun}, 1);
    check("ovr_hold_d", {16'd0, mem_d}, 32'h1111);
    do_ack(6, 16'h0000);
    repeat (5) @(negedge clk_sys);
    check("ovr_dropped", {31'd0, mem_req != mem_ack}, 0);
    check("ovr_sticky", {31'd0, dl_overrun}, 1);

    // Address change mid-fetch.
    dl_active = 1'b0;
    wait_req("re1", lat);
    do_ack(1, 16'h2020);
    wait_req("re2", lat);
    do_ack(1, 16'h3030);
    main_addr = 14'h0005;
    wait_req("chg", lat);
    check("chg_a5", {9'd0, mem_a}, 32'h5);
    main_addr = 14'h0006;
    do_ack(2, 16'hBEEF);
    check("chg_stored_not_ready", {15'd0, main_ready, main_q}, 32'h0_BEEF);
    wait_req("chg6", lat);
    check("chg_a6", {9'd0, mem_a}, 32'h6);
    do_ack(1, 16'hC0DE);
    check("chg6_fill", {15'd0, main_ready, main_q}, 32'h1_C0DE);

    // Reset mid-transfer; arrange for the aborted request to have mem_req = 0.
    if (mem_ack == 1'b0) begin
      main_addr = 14'h0007;
      wait_req("parity", lat);
      do_ack(1, 16'h0707);
    end
    main_addr = 14'h0100;
    wait_req("abort", lat);
    reset = 1'b1;
    #1;
    check("abort_req", {31'd0, mem_req}, 0);
    check("abort_outs", {7'd0, mem_a, mem_ds}, 0);
    check("abort_we_d", {15'd0, mem_we, mem_d}, 0);
    check("abort_q", {main_q, snd_q}, 0);
    check("abort_flags", {29'd0, main_ready, snd_ready, dl_overrun}, 0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("sync_hold", {30'd0, mem_req, mem_ack}, 32'b01);
    mem_q = 16'hDEAD; mem_ack = 1'b0;
    @(negedge clk_sys);
    check("sync_no_capture", {15'd0, main_ready, main_q}, 0);
    wait_req("resume", lat);
    check("resume_a", {9'd0, mem_a}, 32'h100);
    do_ack(1, 16'h5151);
    check("resume_fill", {15'd0, main_ready, main_q}, 32'h1_5151);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
